// File: rtl/fb_arbiter.sv
// fb_arbiter: owns the framebuffer RAM port; bursts one line into the line buffer per displayed line,
// fills the remaining cycles with single-word CPU accesses. Optional FB_ARB_UNDERRUN_CNT_EN adds an underrun counter.
module fb_arbiter #(
   parameter int                ADDR_W     = 16,
   parameter int                DATA_W     = 16,
   parameter int                LINE_WORDS = 40,
   parameter logic [ADDR_W-1:0] FB_BASE    = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              line_start,
   input  logic              vlookahead,
   input  logic [9:0]        y,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              lb_we,
   output logic [5:0]        lb_addr,
   output logic [DATA_W-1:0] lb_wdata,
   output logic              fetch_busy,
`ifdef FB_ARB_UNDERRUN_CNT_EN
   input  logic              underrun_clr,
   output logic [15:0]       underrun_cnt,
`endif
   output logic              underrun
);

   localparam logic [5:0] LAST_IDX = 6'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, FETCH, CPU} state_t;

   state_t            state, state_nxt;
   logic              trig;
   logic              fetch_pend;
   logic [ADDR_W-1:0] row_base;
   logic [5:0]        idx;
   logic              vld_p1;
   logic [5:0]        lb_addr_p1;
   logic              ack_p1;
   logic              rd_p1;
   logic [DATA_W-1:0] rdata_hold;

   function automatic logic [ADDR_W-1:0] row_addr(input logic [9:0] row);
      return FB_BASE + ADDR_W'(row) * ADDR_W'(LINE_WORDS);
   endfunction

   assign trig = line_start & vlookahead;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (fetch_pend || trig)
               state_nxt = FETCH;
            else if (cpu_req)
               state_nxt = CPU;
         end
         FETCH: begin
            if (!trig && idx == LAST_IDX)
               state_nxt = IDLE;
         end
         CPU:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (state == FETCH) begin
         mem_addr = row_base + ADDR_W'(idx);
      end else if (state == CPU) begin
         mem_addr  = cpu_addr;
         mem_we    = cpu_we;
         mem_wdata = cpu_wdata;
      end
   end

   // p0 -> p1: RAM read data returns one cycle after the address, so line-buffer
   // writes and CPU acks are tracked one stage behind the issuing state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         fetch_pend <= 1'b0;
         idx        <= '0;
         vld_p1     <= 1'b0;
         lb_addr_p1 <= '0;
         ack_p1     <= 1'b0;
         rd_p1      <= 1'b0;
         underrun   <= 1'b0;
         rdata_hold <= '0;
      end else begin
         state      <= state_nxt;
         // A trigger can only wait while the CPU grant cycle finishes.
         fetch_pend <= (state == CPU) && (fetch_pend || trig);
         idx        <= (state == FETCH && !trig && idx != LAST_IDX) ? idx + 6'd1 : 6'd0;
         vld_p1     <= (state == FETCH);
         lb_addr_p1 <= idx;
         ack_p1     <= (state == CPU);
         rd_p1      <= (state == CPU) && !cpu_we;
         underrun   <= trig && fetch_busy;
         if (ack_p1 && rd_p1)
            rdata_hold <= mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (trig)
         row_base <= row_addr(y);
   end

   assign lb_we      = vld_p1;
   assign lb_addr    = lb_addr_p1;
   assign lb_wdata   = vld_p1 ? mem_rdata : '0;
   assign fetch_busy = (state == FETCH) || vld_p1;
   assign cpu_ack    = ack_p1;
   assign cpu_rdata  = (ack_p1 && rd_p1) ? mem_rdata : rdata_hold;

`ifdef FB_ARB_UNDERRUN_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         underrun_cnt <= '0;
      else if (underrun_clr)
         underrun_cnt <= '0;
      else if (underrun && underrun_cnt != 16'hFFFF)
         underrun_cnt <= underrun_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: scoreboarded line-buffer writes and CPU acks plus per-scenario timing checks.
`timescale 1ns/1ps
module tb_fb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        line_start, line_start2, vlookahead;
   logic [9:0]  y;
   logic        cpu_req, cpu_we, cpu_req2;
   logic [15:0] cpu_addr, cpu_wdata;
   logic        cpu_ack, mem_we, lb_we, fetch_busy, underrun;
   logic [15:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata, lb_wdata;
   logic [5:0]  lb_addr;
   logic        cpu_ack2, mem_we2, lb_we2, fetch_busy2, underrun2;
   logic [15:0] cpu_rdata2, mem_addr2, mem_wdata2, mem_rdata2, lb_wdata2;
   logic [5:0]  lb_addr2;
`ifdef FB_ARB_UNDERRUN_CNT_EN
   logic        underrun_clr, underrun_clr2;
   logic [15:0] underrun_cnt, underrun_cnt2;
`endif

   typedef struct { logic [5:0] idx; logic [15:0] data; } lb_exp_t;
   typedef struct { logic rd; logic [15:0] data; } cpu_exp_t;
   lb_exp_t  exp_lb[$];
   cpu_exp_t exp_cpu[$];
   lb_exp_t  le;
   cpu_exp_t ce;
   int n_vec = 0;
   int n_err = 0;
   bit lb_chk = 1'b1;

   logic        wr_vld;
   logic [15:0] wr_addr_m, wr_data_m;

   always #5 clk = ~clk;

   fb_arbiter dut (
      .clk(clk), .rst(rst), .line_start(line_start), .vlookahead(vlookahead), .y(y),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_addr(lb_addr),
      .lb_wdata(lb_wdata), .fetch_busy(fetch_busy),
`ifdef FB_ARB_UNDERRUN_CNT_EN
      .underrun_clr(underrun_clr), .underrun_cnt(underrun_cnt),
`endif
      .underrun(underrun)
   );

   fb_arbiter #(.FB_BASE(16'hFFF0)) dut2 (
      .clk(clk), .rst(rst), .line_start(line_start2), .vlookahead(vlookahead), .y(y),
      .cpu_req(cpu_req2), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack2), .cpu_rdata(cpu_rdata2), .mem_addr(mem_addr2), .mem_we(mem_we2),
      .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .lb_we(lb_we2), .lb_addr(lb_addr2),
      .lb_wdata(lb_wdata2), .fetch_busy(fetch_busy2),
`ifdef FB_ARB_UNDERRUN_CNT_EN
      .underrun_clr(underrun_clr2), .underrun_cnt(underrun_cnt2),
`endif
      .underrun(underrun2)
   );

   function automatic logic [15:0] pat(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h3C5A;
   endfunction

   // RAM model: fixed pattern everywhere except the most recently written word.
   always @(posedge clk) begin
      if (rst) begin
         wr_vld <= 1'b0;
      end else if (mem_we) begin
         wr_vld    <= 1'b1;
         wr_addr_m <= mem_addr;
         wr_data_m <= mem_wdata;
      end
      mem_rdata  <= (wr_vld && wr_addr_m == mem_addr) ? wr_data_m : pat(mem_addr);
      mem_rdata2 <= (wr_vld && wr_addr_m == mem_addr2) ? wr_data_m : pat(mem_addr2);
   end

   always begin
      @(posedge clk);
      #1;
      if (lb_we && lb_chk) begin
         n_vec++;
         if (exp_lb.size() == 0) begin
            n_err++;
            $display("FAIL lb_write: unexpected write idx %0d data %h, none required", lb_addr, lb_wdata);
         end else begin
            le = exp_lb.pop_front();
            if (lb_addr !== le.idx || lb_wdata !== le.data) begin
               n_err++;
               $display("FAIL lb_write: got idx %0d data %h, want idx %0d data %h", lb_addr, lb_wdata, le.idx, le.data);
            end
         end
      end
      if (cpu_ack) begin
         n_vec++;
         if (exp_cpu.size() == 0) begin
            n_err++;
            $display("FAIL cpu_ack: unexpected ack, rdata %h", cpu_rdata);
         end else begin
            ce = exp_cpu.pop_front();
            if (ce.rd && cpu_rdata !== ce.data) begin
               n_err++;
               $display("FAIL cpu_rdata: got %h want %h", cpu_rdata, ce.data);
            end
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_row(input logic [15:0] base, input int n);
      for (int i = 0; i < n; i++)
         exp_lb.push_back('{idx: 6'(i), data: pat(base + 16'(i))});
   endtask

   task automatic test_reset();
      repeat (3) tick();
      n_vec++;
      if ({cpu_ack, mem_we, lb_we, fetch_busy, underrun} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b want 00000", {cpu_ack, mem_we, lb_we, fetch_busy, underrun});
      end
      n_vec++;
      if ({cpu_rdata, mem_addr, mem_wdata, lb_wdata, lb_addr} !== 70'd0) begin
         n_err++;
         $display("FAIL reset_data: rdata %h addr %h wdata %h lbw %h lba %0d, want all 0",
                  cpu_rdata, mem_addr, mem_wdata, lb_wdata, lb_addr);
      end
`ifdef FB_ARB_UNDERRUN_CNT_EN
      n_vec++;
      if (underrun_cnt !== 16'h0) begin
         n_err++;
         $display("FAIL reset_cnt: got %h want 0000", underrun_cnt);
      end
`endif
      rst = 1'b0;
      tick();
      n_vec++;
      if (fetch_busy !== 1'b0 || mem_addr !== 16'h0) begin
         n_err++;
         $display("FAIL post_reset_idle: busy %b addr %h want 0 0000", fetch_busy, mem_addr);
      end
   endtask

   task automatic test_basic_fetch();
      int busy_n;
      logic [15:0] ea;
      busy_n = 0;
      y = 10'd3;
      vlookahead = 1'b1;
      line_start = 1'b1;
      push_row(16'd120, 40);
      for (int k = 1; k <= 45; k++) begin
         tick();
         line_start = 1'b0;
         if (fetch_busy) busy_n++;
         if (k <= 40) begin
            ea = 16'(119 + k);
            n_vec++;
            if (mem_addr !== ea || mem_we !== 1'b0) begin
               n_err++;
               $display("FAIL basic_addr k=%0d: got %h we %b want %h we 0", k, mem_addr, mem_we, ea);
            end
         end
         n_vec++;
         if (lb_we !== (k >= 2 && k <= 41)) begin
            n_err++;
            $display("FAIL basic_lb_we k=%0d: got %b want %b", k, lb_we, (k >= 2 && k <= 41));
         end
         n_vec++;
         if (fetch_busy !== (k <= 41)) begin
            n_err++;
            $display("FAIL basic_busy k=%0d: got %b want %b", k, fetch_busy, (k <= 41));
         end
      end
      n_vec++;
      if (busy_n != 41) begin
         n_err++;
         $display("FAIL basic_busy_len: got %0d want 41", busy_n);
      end
      n_vec++;
      if (exp_lb.size() != 0) begin
         n_err++;
         $display("FAIL basic_lb_count: %0d writes missing, want 0", exp_lb.size());
      end
   endtask

   task automatic test_cpu_write_read();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'hBEEF;
      exp_cpu.push_back('{rd: 1'b0, data: 16'h0000});
      tick();
      n_vec++;
      if (mem_we !== 1'b1 || mem_addr !== 16'h0100 || mem_wdata !== 16'hBEEF || cpu_ack !== 1'b0) begin
         n_err++;
         $display("FAIL cpu_wr_grant: we %b addr %h data %h ack %b want 1 0100 beef 0", mem_we, mem_addr, mem_wdata, cpu_ack);
      end
      tick();
      n_vec++;
      if (cpu_ack !== 1'b1) begin
         n_err++;
         $display("FAIL cpu_wr_ack: got %b want 1", cpu_ack);
      end
      cpu_req = 1'b0; cpu_we = 1'b0;
      tick();
      n_vec++;
      if (cpu_ack !== 1'b0) begin
         n_err++;
         $display("FAIL cpu_ack_pulse: got %b want 0", cpu_ack);
      end
      cpu_req = 1'b1;
      exp_cpu.push_back('{rd: 1'b1, data: 16'hBEEF});
      tick();
      n_vec++;
      if (mem_we !== 1'b0 || mem_addr !== 16'h0100) begin
         n_err++;
         $display("FAIL cpu_rd_grant: we %b addr %h want 0 0100", mem_we, mem_addr);
      end
      tick();
      n_vec++;
      if (cpu_ack !== 1'b1 || cpu_rdata !== 16'hBEEF) begin
         n_err++;
         $display("FAIL cpu_rd_ack: ack %b rdata %h want 1 beef", cpu_ack, cpu_rdata);
      end
      cpu_req = 1'b0;
      tick();
      n_vec++;
      if (cpu_ack !== 1'b0 || cpu_rdata !== 16'hBEEF) begin
         n_err++;
         $display("FAIL cpu_rdata_hold: ack %b rdata %h want 0 beef", cpu_ack, cpu_rdata);
      end
   endtask

   task automatic test_contention();
      int ack_k;
      ack_k = -1;
      y = 10'd1; line_start = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
      push_row(16'd40, 40);
      exp_cpu.push_back('{rd: 1'b1, data: pat(16'h0005)});
      for (int k = 1; k <= 95 && !(ack_k < 0 && k > 50); k++) begin
         tick();
         line_start = 1'b0;
         if (cpu_ack && ack_k < 0) begin
            ack_k = k;
            cpu_req = 1'b0;
         end
         if (k == 42) begin
            n_vec++;
            if (mem_addr !== 16'h0005 || fetch_busy !== 1'b0) begin
               n_err++;
               $display("FAIL cont_grant: addr %h busy %b want 0005 0", mem_addr, fetch_busy);
            end
            y = 10'd2; line_start = 1'b1;
            push_row(16'd80, 40);
         end
         if (k == 43) begin
            n_vec++;
            if (mem_addr !== 16'h0000 || fetch_busy !== 1'b0) begin
               n_err++;
               $display("FAIL cont_delay: addr %h busy %b want 0000 0", mem_addr, fetch_busy);
            end
         end
         if (k == 44) begin
            n_vec++;
            if (mem_addr !== 16'd80 || fetch_busy !== 1'b1) begin
               n_err++;
               $display("FAIL cont_fetch2: addr %h busy %b want 0050 1", mem_addr, fetch_busy);
            end
         end
      end
      cpu_req = 1'b0;
      n_vec++;
      if (ack_k != 43) begin
         n_err++;
         $display("FAIL cont_ack_cycle: got %0d want 43", ack_k);
      end
      n_vec++;
      if (exp_lb.size() != 0 || exp_cpu.size() != 0) begin
         n_err++;
         $display("FAIL cont_pending: lb %0d cpu %0d left, want 0 0", exp_lb.size(), exp_cpu.size());
      end
   endtask

   task automatic test_underrun();
      int pulses;
      pulses = 0;
`ifdef FB_ARB_UNDERRUN_CNT_EN
      underrun_clr = 1'b1;
      tick();
      underrun_clr = 1'b0;
      tick();
      n_vec++;
      if (underrun_cnt !== 16'h0) begin
         n_err++;
         $display("FAIL urun_clr: got %h want 0000", underrun_cnt);
      end
`endif
      y = 10'd4; line_start = 1'b1;
      push_row(16'd160, 10);
      for (int k = 1; k <= 60; k++) begin
         tick();
         line_start = 1'b0;
         if (underrun) pulses++;
         if (k == 10) begin
            n_vec++;
            if (mem_addr !== 16'd169) begin
               n_err++;
               $display("FAIL urun_pre: addr %h want 00a9", mem_addr);
            end
            y = 10'd5; line_start = 1'b1;
            push_row(16'd200, 40);
         end
         if (k == 11) begin
            n_vec++;
            if (mem_addr !== 16'd200 || underrun !== 1'b1) begin
               n_err++;
               $display("FAIL urun_restart: addr %h underrun %b want 00c8 1", mem_addr, underrun);
            end
         end
      end
      n_vec++;
      if (pulses != 1) begin
         n_err++;
         $display("FAIL urun_pulses: got %0d want 1", pulses);
      end
      n_vec++;
      if (exp_lb.size() != 0) begin
         n_err++;
         $display("FAIL urun_lb_count: %0d writes missing, want 0", exp_lb.size());
      end
`ifdef FB_ARB_UNDERRUN_CNT_EN
      n_vec++;
      if (underrun_cnt !== 16'd1) begin
         n_err++;
         $display("FAIL urun_cnt: got %h want 0001", underrun_cnt);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int acks;
      acks = 0;
      y = 10'd1; line_start = 1'b1;
      push_row(16'd40, 40);
      for (int k = 1; k <= 21; k++) begin
         tick();
         line_start = 1'b0;
      end
      n_vec++;
      if (mem_addr !== 16'd60) begin
         n_err++;
         $display("FAIL rmid_pos: addr %h want 003c", mem_addr);
      end
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if ({mem_addr, mem_wdata, lb_wdata, cpu_rdata, lb_addr, mem_we, lb_we, fetch_busy, cpu_ack, underrun} !== 75'd0) begin
         n_err++;
         $display("FAIL rmid_fetch_outs: addr %h lba %0d lbw %h busy %b lbwe %b want all 0",
                  mem_addr, lb_addr, lb_wdata, fetch_busy, lb_we);
      end
      exp_lb.delete();
      tick();
      tick();
      rst = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0007;
      tick();
      n_vec++;
      if (mem_addr !== 16'h0007) begin
         n_err++;
         $display("FAIL rmid_grant: addr %h want 0007", mem_addr);
      end
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if (mem_addr !== 16'h0 || mem_we !== 1'b0 || cpu_ack !== 1'b0 || cpu_rdata !== 16'h0) begin
         n_err++;
         $display("FAIL rmid_cpu_outs: addr %h we %b ack %b rdata %h want 0000 0 0 0000", mem_addr, mem_we, cpu_ack, cpu_rdata);
      end
      cpu_req = 1'b0;
      tick();
      if (cpu_ack) acks++;
      tick();
      if (cpu_ack) acks++;
      rst = 1'b0;
      repeat (3) begin
         tick();
         if (cpu_ack) acks++;
      end
      n_vec++;
      if (acks != 0) begin
         n_err++;
         $display("FAIL rmid_no_ack: got %0d acks want 0", acks);
      end
      y = 10'd2; line_start = 1'b1;
      push_row(16'd80, 40);
      for (int k = 1; k <= 45; k++) begin
         tick();
         line_start = 1'b0;
         if (k == 1) begin
            n_vec++;
            if (mem_addr !== 16'd80 || fetch_busy !== 1'b1) begin
               n_err++;
               $display("FAIL rmid_refetch: addr %h busy %b want 0050 1", mem_addr, fetch_busy);
            end
         end
      end
      n_vec++;
      if (exp_lb.size() != 0) begin
         n_err++;
         $display("FAIL rmid_lb_count: %0d writes missing, want 0", exp_lb.size());
      end
   endtask

   task automatic test_vlook0();
      int bad;
      bad = 0;
      vlookahead = 1'b0; y = 10'd3; line_start = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         line_start = 1'b0;
         if (fetch_busy !== 1'b0 || mem_addr !== 16'h0) bad++;
      end
      vlookahead = 1'b1;
      n_vec++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL vlook0: got %0d busy cycles want 0", bad);
      end
   endtask

   task automatic test_wrap();
      logic [15:0] ea;
      y = 10'd0; line_start2 = 1'b1;
      for (int k = 1; k <= 43; k++) begin
         tick();
         line_start2 = 1'b0;
         if (k <= 40) begin
            ea = 16'hFFF0 + 16'(k - 1);
            n_vec++;
            if (mem_addr2 !== ea) begin
               n_err++;
               $display("FAIL wrap_addr k=%0d: got %h want %h", k, mem_addr2, ea);
            end
         end
         if (k >= 2 && k <= 41) begin
            ea = 16'hFFF0 + 16'(k - 2);
            n_vec++;
            if (lb_we2 !== 1'b1 || lb_addr2 !== 6'(k - 2) || lb_wdata2 !== pat(ea)) begin
               n_err++;
               $display("FAIL wrap_lb k=%0d: we %b idx %0d data %h want 1 %0d %h", k, lb_we2, lb_addr2, lb_wdata2, k - 2, pat(ea));
            end
         end
      end
      n_vec++;
      if ({cpu_ack2, mem_we2, fetch_busy2, underrun2} !== 4'b0 || cpu_rdata2 !== 16'h0 || mem_wdata2 !== 16'h0) begin
         n_err++;
         $display("FAIL wrap_idle: ack %b we %b busy %b urun %b rdata %h wdata %h want all 0",
                  cpu_ack2, mem_we2, fetch_busy2, underrun2, cpu_rdata2, mem_wdata2);
      end
   endtask

`ifdef FB_ARB_UNDERRUN_CNT_EN
   task automatic test_cnt_saturate();
      lb_chk = 1'b0;
      y = 10'd3; line_start = 1'b1;
      repeat (65600) tick();
      n_vec++;
      if (underrun_cnt !== 16'hFFFF) begin
         n_err++;
         $display("FAIL cnt_sat: got %h want ffff", underrun_cnt);
      end
      repeat (3) tick();
      n_vec++;
      if (underrun_cnt !== 16'hFFFF || underrun !== 1'b1) begin
         n_err++;
         $display("FAIL cnt_hold: cnt %h urun %b want ffff 1", underrun_cnt, underrun);
      end
      underrun_clr = 1'b1;
      tick();
      underrun_clr = 1'b0;
      n_vec++;
      if (underrun_cnt !== 16'h0) begin
         n_err++;
         $display("FAIL cnt_clr_priority: got %h want 0000", underrun_cnt);
      end
      line_start = 1'b0;
      repeat (50) tick();
      exp_lb.delete();
      lb_chk = 1'b1;
   endtask
`endif

   initial begin
      rst = 1'b1;
      line_start = 1'b0; line_start2 = 1'b0; vlookahead = 1'b1; y = '0;
      cpu_req = 1'b0; cpu_req2 = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
`ifdef FB_ARB_UNDERRUN_CNT_EN
      underrun_clr = 1'b0; underrun_clr2 = 1'b0;
`endif
      test_reset();
      test_basic_fetch();
      test_cpu_write_read();
      test_contention();
      test_underrun();
      test_reset_mid();
      test_vlook0();
      test_wrap();
`ifdef FB_ARB_UNDERRUN_CNT_EN
      test_cnt_saturate();
`endif
      tick();
      n_vec++;
      if (exp_cpu.size() != 0) begin
         n_err++;
         $display("FAIL cpu_pending: %0d acks missing, want 0", exp_cpu.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
